// File: rtl/rx_word_align.sv
// Word-alignment stage: barrel-shifts the deserialized stream until the training
// pattern repeats MATCH_CNT times, then locks the offset and flags DONE (or ERR).
module rx_word_align #(
  parameter int unsigned              DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0]    TRAIN_PATTERN = 8'hF0,
  parameter int unsigned              MATCH_CNT     = 4,
  parameter int unsigned              SETTLE_WORDS  = 2,
  parameter int unsigned              MAX_SWEEPS    = 2
) (
  input  logic                          SCLK,
  input  logic                          RESET,
  input  logic                          BIT_ALGN_DONE,
  input  logic                          WORD_ALGN_RSTRT,
  input  logic [DATA_WIDTH-1:0]         RX_DATA,
  input  logic                          RX_VALID,
  output logic [DATA_WIDTH-1:0]         ALGN_DATA,
  output logic                          ALGN_VALID,
  output logic                          WORD_ALGN_DONE,
  output logic                          WORD_ALGN_ERR,
  output logic [$clog2(DATA_WIDTH)-1:0] WORD_ALGN_OFFSET
);

  localparam int OFF_W = $clog2(DATA_WIDTH);
  localparam int SET_W = (SETTLE_WORDS > 0) ? $clog2(SETTLE_WORDS + 1) : 1;
  localparam int MAT_W = $clog2(MATCH_CNT + 1);
  localparam int SWP_W = (MAX_SWEEPS > 0) ? $clog2(MAX_SWEEPS + 1) : 1;

  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(DATA_WIDTH - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_WORDS > 0) ? SETTLE_WORDS - 1 : 0);
  localparam logic [MAT_W-1:0] MAT_LAST = MAT_W'(MATCH_CNT - 1);
  localparam logic [SWP_W-1:0] SWP_MAX  = SWP_W'(MAX_SWEEPS);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CHECK, S_LOCKED, S_ERROR} state_t;

  typedef struct packed {
    logic [OFF_W-1:0] offset;
    logic [SET_W-1:0] settle;
    logic [MAT_W-1:0] match;
    logic [SWP_W-1:0] sweep;
  } ctx_t;

  state_t                    state, state_n;
  ctx_t                      ctx, ctx_n;
  logic [DATA_WIDTH-1:0]     prev;
  logic [2*DATA_WIDTH-1:0]   window;
  logic [DATA_WIDTH-1:0]     shifted;

  assign window  = {RX_DATA, prev};
  assign shifted = window[ctx.offset +: DATA_WIDTH];

  always_comb begin
    state_n = state;
    ctx_n   = ctx;
    if (WORD_ALGN_RSTRT || !BIT_ALGN_DONE) begin
      state_n = S_IDLE;
      ctx_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          ctx_n   = '0;
          state_n = S_SETTLE;
        end
        S_SETTLE: begin
          if (SETTLE_WORDS == 0) begin
            state_n      = S_CHECK;
            ctx_n.settle = '0;
            ctx_n.match  = '0;
          end else if (RX_VALID) begin
            if (ctx.settle == SET_LAST) begin
              state_n      = S_CHECK;
              ctx_n.settle = '0;
              ctx_n.match  = '0;
            end else begin
              ctx_n.settle = ctx.settle + 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (RX_VALID) begin
            if (shifted == TRAIN_PATTERN) begin
              ctx_n.match = ctx.match + 1'b1;
              if (ctx.match == MAT_LAST) state_n = S_LOCKED;
            end else begin
              ctx_n.match  = '0;
              ctx_n.settle = '0;
              state_n      = S_SETTLE;
              if (ctx.offset == OFF_LAST) begin
                // Wrapping past the last offset closes one full sweep.
                ctx_n.offset = '0;
                ctx_n.sweep  = (ctx.sweep == SWP_MAX) ? ctx.sweep : ctx.sweep + 1'b1;
                if (ctx_n.sweep == SWP_MAX) state_n = S_ERROR;
              end else begin
                ctx_n.offset = ctx.offset + 1'b1;
              end
            end
          end
        end
        S_LOCKED: state_n = S_LOCKED;
        S_ERROR:  state_n = S_ERROR;
        default: begin
          state_n = S_IDLE;
          ctx_n   = '0;
        end
      endcase
    end
  end

  // Status flags follow the next state so they rise one cycle after the deciding word.
  always_ff @(posedge SCLK) begin
    if (RESET) begin
      state          <= S_IDLE;
      ctx            <= '0;
      prev           <= '0;
      ALGN_DATA      <= '0;
      ALGN_VALID     <= 1'b0;
      WORD_ALGN_DONE <= 1'b0;
      WORD_ALGN_ERR  <= 1'b0;
    end else begin
      state          <= state_n;
      ctx            <= ctx_n;
      ALGN_VALID     <= RX_VALID;
      WORD_ALGN_DONE <= (state_n == S_LOCKED);
      WORD_ALGN_ERR  <= (state_n == S_ERROR);
      if (RX_VALID) begin
        prev      <= RX_DATA;
        ALGN_DATA <= shifted;
      end
    end
  end

  assign WORD_ALGN_OFFSET = ctx.offset;

endmodule

// File: tb/tb_rx_word_align.sv
// Randomized bench for rx_word_align against a word-counting reference model.
module tb_rx_word_align;

  localparam int DW     = 8;
  localparam int SETTLE = 2;
  localparam int MATCH  = 4;
  localparam int MAXS   = 2;

  logic          SCLK = 1'b0;
  logic          RESET, BIT_ALGN_DONE, WORD_ALGN_RSTRT, RX_VALID;
  logic [DW-1:0] RX_DATA, ALGN_DATA;
  logic          ALGN_VALID, WORD_ALGN_DONE, WORD_ALGN_ERR;
  logic [2:0]    WORD_ALGN_OFFSET;

  always #5 SCLK = ~SCLK;

  rx_word_align dut (
    .SCLK(SCLK), .RESET(RESET), .BIT_ALGN_DONE(BIT_ALGN_DONE),
    .WORD_ALGN_RSTRT(WORD_ALGN_RSTRT), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .ALGN_DATA(ALGN_DATA), .ALGN_VALID(ALGN_VALID), .WORD_ALGN_DONE(WORD_ALGN_DONE),
    .WORD_ALGN_ERR(WORD_ALGN_ERR), .WORD_ALGN_OFFSET(WORD_ALGN_OFFSET)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: m_seen counts valid words since the last offset change; any mismatch
  // restarts it, so matches in a row are simply m_seen - SETTLE.
  bit            m_run, m_lock, m_err, m_avld;
  int            m_seen, m_off, m_sweeps;
  logic [DW-1:0] m_prev, m_algn;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_run = 0; m_lock = 0; m_err = 0; m_seen = 0; m_off = 0; m_sweeps = 0;
  endtask

  task automatic model_step(bit rst, bit bdone, bit rstrt, logic [DW-1:0] d, bit v);
    logic [2*DW-1:0] win;
    logic [DW-1:0]   sh;
    win = {d, m_prev};
    sh  = DW'(win >> m_off);
    if (rst) begin
      model_clear();
      m_prev = '0; m_algn = '0; m_avld = 0;
      return;
    end
    m_avld = v;
    if (v) begin
      m_algn = sh;
      m_prev = d;
    end
    if (rstrt || !bdone) model_clear();
    else if (!m_run) m_run = 1;
    else if (v && !m_lock && !m_err) begin
      m_seen++;
      if (m_seen > SETTLE) begin
        if (sh == 8'hF0) begin
          if (m_seen == SETTLE + MATCH) m_lock = 1;
        end else begin
          m_seen = 0;
          m_off++;
          if (m_off == DW) begin
            m_off = 0;
            m_sweeps++;
            if (m_sweeps == MAXS) m_err = 1;
          end
        end
      end
    end
  endtask

  task automatic cyc(bit rst, bit bdone, bit rstrt, logic [DW-1:0] d, bit v);
    RESET = rst; BIT_ALGN_DONE = bdone; WORD_ALGN_RSTRT = rstrt; RX_DATA = d; RX_VALID = v;
    @(posedge SCLK);
    model_step(rst, bdone, rstrt, d, v);
    #1;
    chk("algn_data",  32'(ALGN_DATA),        32'(m_algn));
    chk("algn_valid", 32'(ALGN_VALID),       32'(m_avld));
    chk("done",       32'(WORD_ALGN_DONE),   32'(m_lock));
    chk("err",        32'(WORD_ALGN_ERR),    32'(m_err));
    chk("offset",     32'(WORD_ALGN_OFFSET), m_off);
  endtask

  // Feed constant 1E with RX_VALID every cycle; returns cycles until DONE (0 on timeout).
  task automatic lock_run(output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      cyc(0, 1, 0, 8'h1E, 1);
      if (WORD_ALGN_DONE) begin n = i; break; end
    end
  endtask

  initial begin
    int n, nv;
    model_clear();
    m_prev = '0; m_algn = '0; m_avld = 0;

    // Reset with toggling valid, then idle tracking of window[0+:8]
    cyc(1, 0, 0, 8'($urandom), 1);
    cyc(1, 0, 0, 8'($urandom), 0);
    chk("rst_outputs", {ALGN_DATA, ALGN_VALID, WORD_ALGN_DONE, WORD_ALGN_ERR, WORD_ALGN_OFFSET}, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 8'($urandom), 1);
    chk("idle_no_done", 32'(WORD_ALGN_DONE), 0);

    // Lock at offset 5: one IDLE cycle plus 21 counted words
    lock_run(n);
    chk("lock_latency", n, 22);
    chk("lock_offset", 32'(WORD_ALGN_OFFSET), 5);
    cyc(0, 1, 0, 8'h1E, 1);
    chk("lock_data", 32'(ALGN_DATA), 32'h0F0);

    // Payload after lock
    for (int i = 0; i < 30; i++) cyc(0, 1, 0, 8'($urandom), ($urandom % 3) != 0);
    chk("payload_done", 32'(WORD_ALGN_DONE), 1);
    chk("payload_offset", 32'(WORD_ALGN_OFFSET), 5);

    // Restart pulse while locked, then relock
    cyc(0, 1, 1, 8'h1E, 1);
    chk("rstrt_done", 32'(WORD_ALGN_DONE), 0);
    chk("rstrt_offset", 32'(WORD_ALGN_OFFSET), 0);
    lock_run(n);
    chk("relock_latency", n, 22);

    // Restart held high keeps the block idle
    for (int i = 0; i < 8; i++) cyc(0, 1, 1, 8'h1E, 1);
    chk("rstrt_held", {WORD_ALGN_DONE, WORD_ALGN_OFFSET}, 0);

    // Gapped valid: IDLE cycle then alternating valid
    cyc(0, 0, 0, 8'h1E, 1);
    nv = 0; n = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(0, 1, 0, 8'h1E, (k % 2) == 0);
      if (k > 0 && (k % 2) == 0) nv++;
      if (WORD_ALGN_DONE) begin n = k; break; end
    end
    chk("gap_words", nv, 21);
    chk("gap_cycle", n, 42);
    chk("gap_offset", 32'(WORD_ALGN_OFFSET), 5);

    // Loss of bit alignment mid-CHECK (offset 2 after 8 words)
    cyc(0, 0, 0, 8'h1E, 1);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 8'h1E, 1);
    chk("loss_pre_offset", 32'(WORD_ALGN_OFFSET), 2);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 8'h1E, 1);
    chk("loss_idle", {WORD_ALGN_DONE, WORD_ALGN_OFFSET}, 0);
    lock_run(n);
    chk("loss_relock", n, 22);

    // Error: all-zero stream, 2 sweeps x 8 offsets x 3 words
    cyc(0, 0, 0, 8'h00, 1);
    n = 0;
    for (int i = 1; i <= 80; i++) begin
      cyc(0, 1, 0, 8'h00, 1);
      if (WORD_ALGN_ERR) begin n = i; break; end
    end
    chk("err_latency", n, 49);
    chk("err_done_low", 32'(WORD_ALGN_DONE), 0);
    chk("err_offset", 32'(WORD_ALGN_OFFSET), 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'h1E, 1);
    chk("err_sticky", 32'(WORD_ALGN_ERR), 1);

    // Random soak, biased toward the training stream
    for (int i = 0; i < 600; i++)
      cyc(($urandom % 250) == 0, ($urandom % 60) != 0, ($urandom % 70) == 0,
          (($urandom % 4) == 0) ? 8'($urandom) : 8'h1E, ($urandom % 4) != 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_word_align.md
Name: rx_word_align

Overview:
- Word-alignment stage directly downstream of the RX IOD bit-alignment core in the LVDS/camera receive path.
- Starts once bit alignment reports done.
- Slides a barrel-shift window across consecutive deserialized words until the training pattern is seen MATCH_CNT times in a row, then locks the offset.
- Delivers word-aligned parallel data to the pixel unpacker, plus DONE/ERR status alongside the bit-align flags.

Parameters:
- DATA_WIDTH, 8: deserialization factor, bits per word; must be ≥ 2.
- TRAIN_PATTERN, 8'hF0: aligned training word, DATA_WIDTH bits.
- MATCH_CNT, 4: consecutive matching valid words required for lock; must be ≥ 1.
- SETTLE_WORDS, 2: valid words ignored after every offset change.
- MAX_SWEEPS, 2: full offset sweeps without lock before error.

Ports:
- SCLK  in  1: fabric clock; all logic rising-edge.
- RESET  in  1: synchronous, active-high reset.
- BIT_ALGN_DONE  in  1: bit alignment complete, level.
- WORD_ALGN_RSTRT  in  1: restart word alignment, pulse or level.
- RX_DATA  in  DATA_WIDTH: deserialized word; bit 0 is the earliest received bit.
- RX_VALID  in  1: RX_DATA qualifier.
- ALGN_DATA  out  DATA_WIDTH: shifted word, registered.
- ALGN_VALID  out  1: ALGN_DATA qualifier.
- WORD_ALGN_DONE  out  1: lock achieved.
- WORD_ALGN_ERR  out  1: sweep limit exhausted.
- WORD_ALGN_OFFSET  out  clog2(DATA_WIDTH): current shift offset.

Behaviour:
- Reset (RESET=1 at a clock edge):
  - state=IDLE; prev word, offset, all counters = 0.
  - All outputs 0.
- Window and shift:
  - window = {RX_DATA, prev} (2*DATA_WIDTH bits).
  - shifted = window[offset +: DATA_WIDTH].
  - prev <= RX_DATA only on RX_VALID=1.
- Output path (all states):
  - ALGN_DATA <= shifted and ALGN_VALID <= RX_VALID; 1-cycle latency.
  - ALGN_DATA holds its last value when RX_VALID=0.
  - Consumers gate on WORD_ALGN_DONE.
- States:
  - IDLE: counters = 0, offset = 0. Go to SETTLE when BIT_ALGN_DONE=1.
  - SETTLE: count RX_VALID words. After SETTLE_WORDS valid words, go to CHECK with match_cnt=0.
  - CHECK, on each valid word, compare shifted against TRAIN_PATTERN:
    - Match: match_cnt+1. On the MATCH_CNT-th consecutive match, go to LOCKED.
    - Mismatch, offset < DATA_WIDTH-1: offset+1, go to SETTLE.
    - Mismatch, offset = DATA_WIDTH-1: offset wraps to 0 and sweep_cnt+1. If sweep_cnt reaches MAX_SWEEPS, go to ERROR; otherwise go to SETTLE.
    - Cycles with RX_VALID=0 change nothing.
  - LOCKED: WORD_ALGN_DONE=1; offset frozen. Payload mismatches are ignored.
  - ERROR: WORD_ALGN_ERR=1; offset holds 0.
- Status outputs:
  - WORD_ALGN_DONE and WORD_ALGN_ERR are registered, asserted the cycle after entering LOCKED/ERROR.
  - They are never high together.
- Exits from any state other than IDLE (same cycle):
  - WORD_ALGN_RSTRT=1 or BIT_ALGN_DONE=0 → IDLE.
  - DONE/ERR cleared next cycle; offset and counters cleared.
  - If RSTRT is held high, the block remains in IDLE.
- Priority: RESET > RSTRT > BIT_ALGN_DONE=0 > normal transitions.
- A valid word arriving on the cycle the block leaves CHECK is not counted.
- Counter widths:
  - Sized for their maximum values; no overflow.
  - sweep_cnt saturates at MAX_SWEEPS.

Test Plan:
- Reset and idle: RESET=1 for 2 cycles with RX_VALID toggling → all outputs 0. After release with BIT_ALGN_DONE=0, state stays IDLE; ALGN_DATA tracks window[0+:8].
- Lock at offset 5: BIT_ALGN_DONE=1, RX_DATA=8'h1E constant with RX_VALID every cycle.
  - Offsets 0–4 each fail after 3 words.
  - Offset 5 gives 2 settle words + 4 matches.
  - Required: WORD_ALGN_DONE=1 one cycle after the 21st valid word in SETTLE/CHECK; WORD_ALGN_OFFSET=5; ALGN_DATA=8'hF0 thereafter.
- Gapped valid: same stream as the lock test, RX_VALID alternating 1/0 → same offset 5; DONE after 21 valid words (about 42 cycles); no miscount.
- Error: RX_DATA=8'h00 constant → after 2 sweeps × 8 offsets × 3 words = 48 valid words, WORD_ALGN_ERR=1, DONE=0, OFFSET=0.
- Restart and loss:
  - Restart: while LOCKED, pulse WORD_ALGN_RSTRT for 1 cycle → DONE=0 next cycle, OFFSET=0, relock to 5 after 21 more words.
  - Loss: drop BIT_ALGN_DONE mid-CHECK → IDLE; no DONE until BIT_ALGN_DONE returns.
- Payload after lock: LOCKED, then RX_DATA switches to random values → DONE stays 1, OFFSET stays 5, ALGN_DATA = window[5+:8] of each word, 1-cycle latency.
